// File: rtl/l2_port_arbiter.sv
// Sticky-ownership arbiter sharing one L2 port between icache and dcache; registered grant (one cycle from IDLE), combinational forwarding while granted.
// Non-owners wait with fulfilled low until the owner drops valid; optional L2_ARB_PERF_CNT_EN adds grant/wait counters.
package l2_arb_pkg;
  typedef enum logic [1:0] {LOAD = 2'd0, STORE = 2'd1, CLFLUSH = 2'd2} memory_operation_e;
endpackage

module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef L2_ARB_PERF_CNT_EN
  output logic [31:0]       ic_grant_count,
  output logic [31:0]       dc_grant_count,
  output logic [31:0]       ic_wait_cycles,
  output logic [31:0]       dc_wait_cycles,
`endif
  input  logic [XLEN-1:0]   ic_req_address,
  input  memory_operation_e ic_req_type,
  input  logic              ic_req_valid,
  input  logic [XLEN-1:0]   ic_word_to_store,
  output logic [XLEN-1:0]   ic_fetched_word,
  output logic              ic_req_fulfilled,
  input  logic [XLEN-1:0]   dc_req_address,
  input  memory_operation_e dc_req_type,
  input  logic              dc_req_valid,
  input  logic [XLEN-1:0]   dc_word_to_store,
  output logic [XLEN-1:0]   dc_fetched_word,
  output logic              dc_req_fulfilled,
  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_word_to_store,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_req_fulfilled
);

  typedef enum logic [1:0] {IDLE, GRANT_IC, GRANT_DC} state_e;
  typedef enum logic {OWNER_IC, OWNER_DC} owner_e;

  state_e r_state;
  owner_e r_last_owner;
  logic   w_tie_dc;
  logic   w_go_ic;
  logic   w_go_dc;
  logic   w_release;

  // A tie goes to DC in fixed-priority mode, otherwise to whoever did not own last.
  always_comb begin
    w_tie_dc  = (ARB_MODE == 1) || (r_last_owner == OWNER_IC);
    w_go_ic   = 1'b0;
    w_go_dc   = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        w_go_ic = ic_req_valid & (~dc_req_valid | ~w_tie_dc);
        w_go_dc = dc_req_valid & (~ic_req_valid | w_tie_dc);
      end
      GRANT_IC: begin
        w_release = ~ic_req_valid;
        w_go_dc   = ~ic_req_valid & dc_req_valid;
      end
      GRANT_DC: begin
        w_release = ~dc_req_valid;
        w_go_ic   = ~dc_req_valid & ic_req_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= OWNER_IC;
    end else begin
      if (w_release) r_last_owner <= (r_state == GRANT_DC) ? OWNER_DC : OWNER_IC;
      if (w_go_ic)        r_state <= GRANT_IC;
      else if (w_go_dc)   r_state <= GRANT_DC;
      else if (w_release) r_state <= IDLE;
    end
  end

  // Owner's request is forwarded combinationally; valid and fulfilment are masked during reset.
  always_comb begin
    l2_req_address   = '0;
    l2_req_type      = LOAD;
    l2_req_valid     = 1'b0;
    l2_word_to_store = '0;
    ic_req_fulfilled = 1'b0;
    dc_req_fulfilled = 1'b0;
    case (r_state)
      GRANT_IC: begin
        l2_req_address   = ic_req_address;
        l2_req_type      = ic_req_type;
        l2_req_valid     = ic_req_valid & ~reset;
        l2_word_to_store = ic_word_to_store;
        ic_req_fulfilled = l2_req_fulfilled & ~reset;
      end
      GRANT_DC: begin
        l2_req_address   = dc_req_address;
        l2_req_type      = dc_req_type;
        l2_req_valid     = dc_req_valid & ~reset;
        l2_word_to_store = dc_word_to_store;
        dc_req_fulfilled = l2_req_fulfilled & ~reset;
      end
      default: ;
    endcase
  end

  assign ic_fetched_word = l2_fetched_word;
  assign dc_fetched_word = l2_fetched_word;

`ifdef L2_ARB_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  logic [31:0] r_ic_grant_count;
  logic [31:0] r_dc_grant_count;
  logic [31:0] r_ic_wait_cycles;
  logic [31:0] r_dc_wait_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ic_grant_count <= '0;
      r_dc_grant_count <= '0;
      r_ic_wait_cycles <= '0;
      r_dc_wait_cycles <= '0;
    end else begin
      if (w_go_ic && r_ic_grant_count != CNT_MAX) r_ic_grant_count <= r_ic_grant_count + 32'd1;
      if (w_go_dc && r_dc_grant_count != CNT_MAX) r_dc_grant_count <= r_dc_grant_count + 32'd1;
      if (ic_req_valid && r_state != GRANT_IC && r_ic_wait_cycles != CNT_MAX)
        r_ic_wait_cycles <= r_ic_wait_cycles + 32'd1;
      if (dc_req_valid && r_state != GRANT_DC && r_dc_wait_cycles != CNT_MAX)
        r_dc_wait_cycles <= r_dc_wait_cycles + 32'd1;
    end
  end

  assign ic_grant_count = r_ic_grant_count;
  assign dc_grant_count = r_dc_grant_count;
  assign ic_wait_cycles = r_ic_wait_cycles;
  assign dc_wait_cycles = r_dc_wait_cycles;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: both arbitration modes side by side, directed table, corner sequences, random run vs ownership model.
module tb_l2_port_arbiter;
  import l2_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [31:0]       ic_addr, dc_addr, ic_st, dc_st, l2_fw;
  memory_operation_e ic_type, dc_type;
  logic              ic_v, dc_v, l2_ful;

  logic [31:0]       o_ic_fw[2], o_dc_fw[2], o_l2_addr[2], o_l2_st[2];
  logic              o_ic_f[2], o_dc_f[2], o_l2_vld[2];
  memory_operation_e o_l2_type[2];
`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0]       o_icg[2], o_dcg[2], o_icw[2], o_dcw[2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    l2_port_arbiter #(.XLEN(32), .ARB_MODE(g)) u_dut (
      .clk(clk), .reset(reset),
`ifdef L2_ARB_PERF_CNT_EN
      .ic_grant_count(o_icg[g]), .dc_grant_count(o_dcg[g]),
      .ic_wait_cycles(o_icw[g]), .dc_wait_cycles(o_dcw[g]),
`endif
      .ic_req_address(ic_addr), .ic_req_type(ic_type), .ic_req_valid(ic_v),
      .ic_word_to_store(ic_st), .ic_fetched_word(o_ic_fw[g]), .ic_req_fulfilled(o_ic_f[g]),
      .dc_req_address(dc_addr), .dc_req_type(dc_type), .dc_req_valid(dc_v),
      .dc_word_to_store(dc_st), .dc_fetched_word(o_dc_fw[g]), .dc_req_fulfilled(o_dc_f[g]),
      .l2_req_address(o_l2_addr[g]), .l2_req_type(o_l2_type[g]), .l2_req_valid(o_l2_vld[g]),
      .l2_word_to_store(o_l2_st[g]), .l2_fetched_word(l2_fw), .l2_req_fulfilled(l2_ful)
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: who owns the port (0 none, 1 ic, 2 dc) and who owned it last.
  int          m_own[2];
  int          m_last[2];
  logic [31:0] m_icg[2], m_dcg[2], m_icw[2], m_dcw[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(int md, int last, logic icv, logic dcv);
    if (icv && dcv) return (md == 1 || last == 1) ? 2 : 1;
    if (icv) return 1;
    if (dcv) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_update();
    for (int md = 0; md < 2; md++) begin
      int old_own;
      old_own = m_own[md];
      if (reset) begin
        m_own[md] = 0; m_last[md] = 1;
        m_icg[md] = 0; m_dcg[md] = 0; m_icw[md] = 0; m_dcw[md] = 0;
      end else begin
        if (ic_v && old_own != 1) m_icw[md] = sat_inc(m_icw[md]);
        if (dc_v && old_own != 2) m_dcw[md] = sat_inc(m_dcw[md]);
        if (!((old_own == 1 && ic_v) || (old_own == 2 && dc_v))) begin
          if (old_own != 0) m_last[md] = old_own;
          m_own[md] = pick(md, m_last[md], ic_v, dc_v);
        end
        if (m_own[md] != old_own && m_own[md] == 1) m_icg[md] = sat_inc(m_icg[md]);
        if (m_own[md] != old_own && m_own[md] == 2) m_dcg[md] = sat_inc(m_dcg[md]);
      end
    end
  endtask

  task automatic model_check();
    for (int md = 0; md < 2; md++) begin
      logic        e_vld;
      logic [31:0] e_addr, e_st;
      logic [1:0]  e_type;
      e_vld  = !reset && ((m_own[md] == 1 && ic_v) || (m_own[md] == 2 && dc_v));
      e_addr = (m_own[md] == 1) ? ic_addr : (m_own[md] == 2) ? dc_addr : 32'h0;
      e_st   = (m_own[md] == 1) ? ic_st : (m_own[md] == 2) ? dc_st : 32'h0;
      e_type = (m_own[md] == 1) ? ic_type : (m_own[md] == 2) ? dc_type : LOAD;
      chk($sformatf("m%0d_l2_vld", md), o_l2_vld[md], e_vld);
      chk($sformatf("m%0d_l2_addr", md), o_l2_addr[md], e_addr);
      chk($sformatf("m%0d_l2_st", md), o_l2_st[md], e_st);
      chk($sformatf("m%0d_l2_type", md), o_l2_type[md], e_type);
      chk($sformatf("m%0d_ic_ful", md), o_ic_f[md], !reset && m_own[md] == 1 && l2_ful);
      chk($sformatf("m%0d_dc_ful", md), o_dc_f[md], !reset && m_own[md] == 2 && l2_ful);
      chk($sformatf("m%0d_fetch", md), {o_ic_fw[md], o_dc_fw[md]}, {l2_fw, l2_fw});
`ifdef L2_ARB_PERF_CNT_EN
      chk($sformatf("m%0d_cnt", md), {o_icg[md], o_dcg[md]}, {m_icg[md], m_dcg[md]});
      chk($sformatf("m%0d_wait", md), {o_icw[md], o_dcw[md]}, {m_icw[md], m_dcw[md]});
`endif
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic tick();
    at_neg();
    at_pos();
  endtask

  typedef struct {
    logic rst, icv, dcv, ful;
    logic e_vld, e_icf, e_dcf;
    logic [31:0] e_addr;
  } vec_t;
  vec_t tbl[15];

  initial begin
    reset = 1'b1; ic_v = 1'b0; dc_v = 1'b0; l2_ful = 1'b0;
    ic_addr = 32'h100; dc_addr = 32'h1230; ic_st = 32'hAAAA_0001; dc_st = 32'hDDDD_0001;
    ic_type = LOAD; dc_type = LOAD; l2_fw = 32'hCAFE_0001;
    for (int md = 0; md < 2; md++) begin
      m_own[md] = 0; m_last[md] = 1; m_icg[md] = 0; m_dcg[md] = 0; m_icw[md] = 0; m_dcw[md] = 0;
    end
    at_pos();

    // Mode-0 directed sequence: tie after reset -> DC, handover without IDLE, second tie -> DC, reset mid-grant.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1230};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1230};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1230};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1230};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; ic_v = tbl[i].icv; dc_v = tbl[i].dcv; l2_ful = tbl[i].ful;
      at_neg();
      chk($sformatf("tbl%0d_vld", i), o_l2_vld[0], tbl[i].e_vld);
      chk($sformatf("tbl%0d_icf", i), o_ic_f[0], tbl[i].e_icf);
      chk($sformatf("tbl%0d_dcf", i), o_dc_f[0], tbl[i].e_dcf);
      chk($sformatf("tbl%0d_addr", i), o_l2_addr[0], tbl[i].e_addr);
      at_pos();
    end

    // Dcache 4-word writeback while icache waits.
    ic_addr = 32'h200; ic_v = 1'b1; dc_v = 1'b1; dc_type = STORE; dc_addr = 32'h4000; l2_ful = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      dc_addr = 32'h4000 + 32'(4 * k); dc_st = 32'h5000 + 32'(k); l2_ful = 1'b1;
      at_neg();
      chk("wb_vld", o_l2_vld[0], 1'b1);
      chk("wb_addr", o_l2_addr[0], 32'h4000 + 32'(4 * k));
      chk("wb_type", o_l2_type[0], STORE);
      chk("wb_icf", o_ic_f[0], 1'b0);
      at_pos();
    end
    dc_v = 1'b0; l2_ful = 1'b0;
    tick();
    at_neg();
    chk("wb_ic_next", {o_l2_vld[0], o_l2_addr[0]}, {1'b1, 32'h200});
    at_pos();
    ic_v = 1'b0;
    tick();

    // Fixed-priority mode: three ties from IDLE all go to DC.
    dc_type = LOAD;
    for (int r = 0; r < 3; r++) begin
      dc_addr = 32'h8000 + 32'(r * 16); ic_v = 1'b1; dc_v = 1'b1; l2_ful = 1'b1;
      tick();
      at_neg();
      chk("m1_tie_dc", {o_l2_vld[1], o_l2_addr[1], o_dc_f[1], o_ic_f[1]},
          {1'b1, 32'h8000 + 32'(r * 16), 1'b1, 1'b0});
      at_pos();
      ic_v = 1'b0; dc_v = 1'b0; l2_ful = 1'b0;
      tick();
    end
    // DC idle at its release edge -> icache finally served.
    ic_v = 1'b1; dc_v = 1'b1;
    tick();
    dc_v = 1'b0;
    tick();
    at_neg();
    chk("m1_ic_after", {o_l2_vld[1], o_l2_addr[1]}, {1'b1, 32'h200});
    at_pos();
    ic_v = 1'b0;
    tick();

`ifdef L2_ARB_PERF_CNT_EN
    reset = 1'b1;
    at_pos();
    reset = 1'b0;
    at_neg();
    chk("perf_reset", {o_icg[0], o_dcg[0], o_icw[0], o_dcw[0]}, 128'h0);
    at_pos();
    dc_v = 1'b1;
    tick();
    ic_v = 1'b1;
    repeat (4) tick();
    dc_v = 1'b0;
    tick();
    tick();
    ic_v = 1'b0;
    tick();
    at_neg();
    chk("perf_ic_wait", o_icw[0], 32'd5);
    chk("perf_dc_grant", o_dcg[0], 32'd1);
    chk("perf_ic_grant", o_icg[0], 32'd1);
    at_pos();
`endif

    // Random traffic against the ownership model.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) ic_v = ~ic_v;
      if ($urandom_range(0, 3) == 0) dc_v = ~dc_v;
      ic_addr = $urandom; dc_addr = $urandom; ic_st = $urandom; dc_st = $urandom;
      ic_type = memory_operation_e'($urandom_range(0, 2));
      dc_type = memory_operation_e'($urandom_range(0, 2));
      l2_ful = 1'($urandom_range(0, 1));
      l2_fw = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 request port between the instruction cache (ic_*) and the data cache (dc_*).
- Grants ownership to one requester and holds it for as long as that requester keeps its valid asserted, so that multi-word line fills and writebacks are never interleaved.
- Forwards the owner's address, type and store data to L2, and returns fulfilment only to the owner.
- Sits between the two L1 caches and L2; both sides use the codebase's valid/fulfilled handshake, with memory_operation_e types LOAD/STORE/CLFLUSH.

Parameters:
- XLEN, 32, address/data width in bits.
- ARB_MODE, 0, 0 = round-robin on release; 1 = fixed priority, dcache wins.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- ic_req_address  input  XLEN  icache request address.
- ic_req_type  input  memory_operation_e  icache request type.
- ic_req_valid  input  1  icache request; held high until it stops needing the port.
- ic_word_to_store  input  XLEN  icache store data.
- ic_fetched_word  output  XLEN  L2 load data (broadcast).
- ic_req_fulfilled  output  1  fulfilment, icache only.
- dc_req_address, dc_req_type, dc_req_valid, dc_word_to_store  inputs, as for ic_*.
- dc_fetched_word  output  XLEN  L2 load data (broadcast).
- dc_req_fulfilled  output  1  fulfilment, dcache only.
- l2_req_address  output  XLEN  forwarded address.
- l2_req_type  output  memory_operation_e  forwarded type.
- l2_req_valid  output  1  forwarded valid.
- l2_word_to_store  output  XLEN  forwarded store data.
- l2_fetched_word  input  XLEN  L2 load data.
- l2_req_fulfilled  input  1  L2 fulfilment (may be combinational from l2_req_valid).

Behaviour:
- States: IDLE, GRANT_IC, GRANT_DC. Register last_owner, which resets to IC.
- Reset (synchronous): state <= IDLE, last_owner <= IC.
  - While reset is high, l2_req_valid = 0 and both *_req_fulfilled = 0, whatever the state.
- Outputs in IDLE: l2_req_valid = 0, l2_req_address = 0, l2_req_type = LOAD, l2_word_to_store = 0.
- Outputs in GRANT_x: l2_req_* = x_req_* combinationally, and l2_req_valid = x_req_valid.
  - x_req_fulfilled = l2_req_fulfilled & (state == GRANT_x).
  - The non-owner's fulfilled output is 0.
- Fetched data: ic_fetched_word = dc_fetched_word = l2_fetched_word (unconditional passthrough).
- IDLE transitions:
  - Only ic_req_valid -> GRANT_IC.
  - Only dc_req_valid -> GRANT_DC.
  - Both valid:
    - ARB_MODE=1 -> GRANT_DC.
    - ARB_MODE=0 -> the requester that is not last_owner (first tie after reset goes to DC).
- Grant latency: a request asserted in cycle N from IDLE gives l2_req_valid high in cycle N+1. This is a registered grant; there is no combinational grant from IDLE.
- GRANT_x hold: the state stays GRANT_x while x_req_valid = 1, regardless of how many words are fulfilled or any change in address/type.
- GRANT_x release: in the cycle x_req_valid = 0, l2_req_valid is 0 combinationally. At that edge:
  - last_owner <= x.
  - If the other requester y is valid, go directly to GRANT_y (no IDLE cycle); otherwise go to IDLE.
  - In ARB_MODE=1 with both valid, DC is chosen.
- Minimum gap between owners: one cycle with l2_req_valid low, namely the owner's deassert cycle.
- Non-owner requests wait; the non-owner's fulfilled output stays 0. A requester must not drop valid before fulfilment, because the arbiter does not abort.
- Starvation:
  - ARB_MODE=0 guarantees alternation when both requesters continuously re-request.
  - ARB_MODE=1 permits icache starvation, by design.
- Reset mid-grant: l2_req_valid drops in the reset cycle and state is IDLE on the next cycle. Pending requests are re-arbitrated from last_owner = IC.
- The arbiter performs no width conversion and no storage of data; only state and last_owner are sequential (plus counters, below).

Optional Feature:
- Macro: L2_ARB_PERF_CNT_EN.
- With the macro defined, four 32-bit output ports are added: ic_grant_count, dc_grant_count, ic_wait_cycles, dc_wait_cycles.
  - A grant count increments on each transition into GRANT_x.
  - wait_cycles increments each cycle x_req_valid = 1 and state != GRANT_x.
  - All four are cleared by reset and saturate at 32'hFFFF_FFFF.
- Without the macro, the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then dc_req_valid=1 at cycle 10 with address 0x0000_1230, LOAD -> l2_req_valid=1 at cycle 11, l2_req_address=0x0000_1230, dc_req_fulfilled mirrors l2 fulfilled, ic_req_fulfilled=0.
- Both valid in the same cycle after reset, ARB_MODE=0 -> DC is granted first. After DC deasserts, the next edge is GRANT_IC with no IDLE cycle. A second simultaneous tie then goes to DC.
- dcache 4-word writeback (STORE to 0x0000_4000/4/8/C, valid held) while ic_req_valid=1 throughout -> all 4 stores reach L2 consecutively before any icache address appears, and ic_req_fulfilled stays 0.
- ARB_MODE=1 with both valid continuously for 3 dcache transactions -> all are granted to DC; icache is granted only when DC is idle at a release edge.
- Reset asserted while in GRANT_IC mid-line -> l2_req_valid=0 in that cycle, state IDLE next, and ic_req_fulfilled=0 during reset.
- L2_ARB_PERF_CNT_EN: ic waits 5 cycles behind a DC grant -> ic_wait_cycles=5, dc_grant_count=1, ic_grant_count=1 after it is served; the counters read 0 after reset.
